// File: rtl/tft_spi_pkg.sv
// Shared types for the streaming TFT SPI transmitter: FSM states, FIFO entry
// layout and frame lengths.
package tft_spi_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   typedef struct packed {
      logic        dc;
      logic        wide;
      logic [15:0] word;
   } entry_t;

   localparam int BITS_NARROW = 8;
   localparam int BITS_WIDE   = 16;
   localparam int ENTRY_W     = $bits(entry_t);
endpackage

// File: rtl/tft_fifo.sv
// Single-clock FIFO with first-word-fall-through read and an occupancy count.
// Pushes while full and pops while empty are ignored.
module tft_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             do_push, do_pop;

   // Full is taken from the registered count, so a pop in the same cycle
   // does not make room for a push.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/tft_spi_stream.sv
// Streaming SPI mode-0 transmitter for TFT panels: queued {dc, word} entries
// go out MSB first as 8- or 16-bit frames, with CS held across back-to-back frames.
module tft_spi_stream
   import tft_spi_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [15:0]      wr_word,
   input  logic             wr_wide,
   input  logic             wr_dc,
   output logic [LVL_W-1:0] fifo_level,
   output logic             overflow,
   input  logic             ovf_clr,
   output logic             busy,
   output logic             tft_clk,
   output logic             tft_mosi,
   output logic             tft_dc,
   output logic             tft_cs
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_t           state, state_n;
   logic [DIV_W-1:0] div_cnt, div_n;
   logic [15:0]      shreg, shreg_n;
   logic [4:0]       bits, bits_n;
   logic             sclk_n, mosi_n, dc_n, cs_n;
   logic             pop, fifo_full, fifo_empty, div_tc;
   entry_t           head, wr_entry;

   assign wr_entry = {wr_dc, wr_wide, wr_word};
   assign wr_ready = !fifo_full;
   assign busy     = (state != IDLE) || (fifo_level != '0);
   assign div_tc   = (div_cnt == DIV_W'(CLK_DIV - 1));

   tft_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (LVL_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_valid),
      .pop   (pop),
      .din   (wr_entry),
      .dout  (head),
      .count (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A fresh overflow event outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         overflow <= 1'b0;
      else if (wr_valid && fifo_full)   overflow <= 1'b1;
      else if (ovf_clr)                 overflow <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         shreg    <= '0;
         bits     <= '0;
         tft_clk  <= 1'b0;
         tft_mosi <= 1'b0;
         tft_dc   <= 1'b0;
         tft_cs   <= 1'b1;
      end else begin
         state    <= state_n;
         div_cnt  <= div_n;
         shreg    <= shreg_n;
         bits     <= bits_n;
         tft_clk  <= sclk_n;
         tft_mosi <= mosi_n;
         tft_dc   <= dc_n;
         tft_cs   <= cs_n;
      end
   end

   always_comb begin
      state_n = state;
      div_n   = div_cnt;
      shreg_n = shreg;
      bits_n  = bits;
      sclk_n  = tft_clk;
      mosi_n  = tft_mosi;
      dc_n    = tft_dc;
      cs_n    = tft_cs;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            cs_n   = 1'b1;
            sclk_n = 1'b0;
            if (!fifo_empty) state_n = LOAD;
         end
         LOAD: begin
            // Narrow frames are left-aligned so both widths shift out of bit 15.
            pop     = 1'b1;
            shreg_n = head.wide ? head.word : {head.word[7:0], 8'h00};
            bits_n  = head.wide ? 5'(BITS_WIDE) : 5'(BITS_NARROW);
            dc_n    = head.dc;
            cs_n    = 1'b0;
            sclk_n  = 1'b0;
            mosi_n  = shreg_n[15];
            div_n   = '0;
            state_n = SHIFT;
         end
         SHIFT: begin
            if (div_tc) begin
               div_n  = '0;
               sclk_n = !tft_clk;
               // Only the falling edge advances the frame; the slave samples on the rise.
               if (tft_clk) begin
                  bits_n = bits - 1'b1;
                  if (bits != 5'd1) begin
                     shreg_n = {shreg[14:0], 1'b0};
                     mosi_n  = shreg[14];
                  end else begin
                     state_n = fifo_empty ? GAP : LOAD;
                  end
               end
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         GAP: begin
            if (div_tc) begin
               div_n   = '0;
               cs_n    = 1'b1;
               state_n = IDLE;
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_tft_spi_stream.sv
// Bench for tft_spi_stream: three instances (CLK_DIV 2/1/7, depth 4) share the
// write port; per-instance SPI slave monitors capture the serial stream.
module tb_tft_spi_stream;
   import tft_spi_pkg::*;

   logic        clk = 1'b0;
   logic        rst, wr_valid, wr_wide, wr_dc, ovf_clr, mon_clr;
   logic [15:0] wr_word;
   logic [2:0]  wr_ready, overflow, busy, tclk, tmosi, tdc, tcs;
   logic [2:0]  lvl0, lvl1, lvl2;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   entry_t      exp_q[$];
   logic [127:0] exp_b, exp_d;
   int          exp_n;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tft_spi_stream #(.CLK_DIV(2), .FIFO_DEPTH(4)) u_dut0 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready[0]), .wr_word(wr_word),
      .wr_wide(wr_wide), .wr_dc(wr_dc), .fifo_level(lvl0), .overflow(overflow[0]),
      .ovf_clr(ovf_clr), .busy(busy[0]), .tft_clk(tclk[0]), .tft_mosi(tmosi[0]),
      .tft_dc(tdc[0]), .tft_cs(tcs[0]));
   tft_spi_stream #(.CLK_DIV(1), .FIFO_DEPTH(4)) u_dut1 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready[1]), .wr_word(wr_word),
      .wr_wide(wr_wide), .wr_dc(wr_dc), .fifo_level(lvl1), .overflow(overflow[1]),
      .ovf_clr(ovf_clr), .busy(busy[1]), .tft_clk(tclk[1]), .tft_mosi(tmosi[1]),
      .tft_dc(tdc[1]), .tft_cs(tcs[1]));
   tft_spi_stream #(.CLK_DIV(7), .FIFO_DEPTH(4)) u_dut2 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready[2]), .wr_word(wr_word),
      .wr_wide(wr_wide), .wr_dc(wr_dc), .fifo_level(lvl2), .overflow(overflow[2]),
      .ovf_clr(ovf_clr), .busy(busy[2]), .tft_clk(tclk[2]), .tft_mosi(tmosi[2]),
      .tft_dc(tdc[2]), .tft_cs(tcs[2]));

   // Slave model: sample mosi/dc on SCLK rise, measure high/low times in clk cycles.
   for (genvar g = 0; g < 3; g++) begin : mon
      localparam int HP = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
      logic [127:0] bits, dcs;
      int nbits, cs_falls, edges, high_bad, low_bad, cs_bad, last_rise, last_fall, cs_gap;
      logic pclk, pcs;
      always @(negedge clk) begin
         pclk <= tclk[g];
         pcs  <= tcs[g];
         if (mon_clr) begin
            bits <= '0; dcs <= '0; nbits <= 0; cs_falls <= 0; edges <= 0;
            high_bad <= 0; low_bad <= 0; cs_bad <= 0; last_rise <= cyc;
            last_fall <= cyc; cs_gap <= -1;
         end else begin
            if (tclk[g] !== pclk) edges <= edges + 1;
            if (tclk[g] === 1'b1 && pclk === 1'b0) begin
               bits      <= {bits[126:0], tmosi[g]};
               dcs       <= {dcs[126:0], tdc[g]};
               nbits     <= nbits + 1;
               last_rise <= cyc;
               if (cyc - last_fall != HP && cyc - last_fall != HP + 1) low_bad <= low_bad + 1;
               if (tcs[g] !== 1'b0) cs_bad <= cs_bad + 1;
            end
            if (tclk[g] === 1'b0 && pclk === 1'b1) begin
               last_fall <= cyc;
               if (cyc - last_rise != HP) high_bad <= high_bad + 1;
            end
            if (tcs[g] === 1'b0 && pcs === 1'b1) begin
               cs_falls  <= cs_falls + 1;
               last_fall <= cyc;
            end
            if (tcs[g] === 1'b1 && pcs === 1'b0) cs_gap <= cyc - last_fall;
         end
      end
   end

   function automatic entry_t mk(input logic dc, input logic wide, input logic [15:0] w);
      entry_t e;
      e.dc = dc; e.wide = wide; e.word = w;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
      exp_q.delete();
   endtask

   task automatic push(input entry_t e);
      wr_dc = e.dc; wr_wide = e.wide; wr_word = e.word; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      exp_q.push_back(e);
   endtask

   // Expected serial stream: each entry's low 8 or 16 bits, MSB first, dc per bit.
   task automatic build_exp();
      exp_b = '0; exp_d = '0; exp_n = 0;
      foreach (exp_q[k]) begin
         int w;
         w = exp_q[k].wide ? 16 : 8;
         for (int i = w - 1; i >= 0; i--) begin
            exp_b = {exp_b[126:0], exp_q[k].word[i]};
            exp_d = {exp_d[126:0], exp_q[k].dc};
            exp_n++;
         end
      end
   endtask

   task automatic wait_idle(input logic [2:0] mask, input int bound, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if ((busy & mask) === 3'b000) begin ok = 1'b1; break; end
         tick();
      end
      repeat (3) tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL %s timeout busy=%b expected 000", name, busy & mask); end
   endtask

   task automatic test_reset();
      rst = 1'b0; wr_valid = 1'b0; wr_wide = 1'b0; wr_dc = 1'b0; wr_word = '0; ovf_clr = 1'b0;
      mon_clr = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      mon_clr = 1'b0;
      checks++; if (tcs !== 3'b111) begin errors++; $display("FAIL reset_cs got %b exp 111", tcs); end
      checks++; if (tclk !== 3'b000) begin errors++; $display("FAIL reset_clk got %b exp 000", tclk); end
      checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b exp 000", busy); end
      checks++; if (wr_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got %b exp 111", wr_ready); end
      checks++; if (lvl0 !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", lvl0); end
      checks++; if (overflow !== 3'b000 || tmosi !== 3'b000 || tdc !== 3'b000) begin
         errors++; $display("FAIL reset_misc ovf=%b mosi=%b dc=%b exp all 0", overflow, tmosi, tdc);
      end
   endtask

   task automatic test_single();
      clear_mon();
      push(mk(1'b0, 1'b0, 16'h002A));
      wait_idle(3'b001, 500, "single_wait");
      build_exp();
      checks++; if (mon[0].nbits != 8) begin errors++; $display("FAIL single_nbits got %0d exp 8", mon[0].nbits); end
      checks++; if (mon[0].bits !== exp_b || exp_b[7:0] !== 8'h2A) begin
         errors++; $display("FAIL single_data got %0h exp %0h", mon[0].bits, exp_b);
      end
      checks++; if (mon[0].dcs !== 128'd0) begin errors++; $display("FAIL single_dc got %0h exp 0", mon[0].dcs); end
      checks++; if (mon[0].cs_falls != 1) begin errors++; $display("FAIL single_cs_windows got %0d exp 1", mon[0].cs_falls); end
      checks++; if (mon[0].high_bad != 0 || mon[0].low_bad != 0 || mon[0].cs_bad != 0) begin
         errors++; $display("FAIL single_sclk_timing high_bad=%0d low_bad=%0d cs_bad=%0d exp 0", mon[0].high_bad, mon[0].low_bad, mon[0].cs_bad);
      end
      checks++; if (mon[0].cs_gap != 2) begin errors++; $display("FAIL single_cs_gap got %0d exp 2", mon[0].cs_gap); end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      push(mk(1'b0, 1'b0, 16'h002C));
      push(mk(1'b1, 1'b1, 16'hF800));
      push(mk(1'b1, 1'b1, 16'h07E0));
      wait_idle(3'b001, 1000, "b2b_wait");
      build_exp();
      checks++; if (mon[0].nbits != 40) begin errors++; $display("FAIL b2b_nbits got %0d exp 40", mon[0].nbits); end
      checks++; if (mon[0].bits !== exp_b) begin errors++; $display("FAIL b2b_data got %0h exp %0h", mon[0].bits, exp_b); end
      checks++; if (mon[0].dcs !== exp_d) begin errors++; $display("FAIL b2b_dc got %0h exp %0h", mon[0].dcs, exp_d); end
      checks++; if (mon[0].cs_falls != 1) begin errors++; $display("FAIL b2b_cs_windows got %0d exp 1", mon[0].cs_falls); end
      checks++; if (mon[0].high_bad != 0 || mon[0].low_bad != 0) begin
         errors++; $display("FAIL b2b_sclk_timing high_bad=%0d low_bad=%0d exp 0", mon[0].high_bad, mon[0].low_bad);
      end
   endtask

   task automatic test_overflow();
      int mlvl = 0;
      bit exp_rdy;
      entry_t e;
      clear_mon();
      // Model: a push into an empty idle queue is popped two edges later; nothing
      // else drains during this burst because the first frame is 16 bits long.
      for (int i = 0; i < 6; i++) begin
         e = mk(1'($urandom_range(0, 1)), 1'b1, 16'($urandom));
         wr_dc = e.dc; wr_wide = e.wide; wr_word = e.word; wr_valid = 1'b1;
         exp_rdy = (mlvl != 4);
         checks++; if (wr_ready[0] !== exp_rdy || lvl0 !== 3'(mlvl)) begin
            errors++; $display("FAIL ovf_burst_%0d ready=%b level=%0d exp ready=%b level=%0d", i, wr_ready[0], lvl0, exp_rdy, mlvl);
         end
         tick();
         if (exp_rdy) begin exp_q.push_back(e); mlvl++; end
         if (i == 2) mlvl--;
      end
      wr_valid = 1'b0;
      checks++; if (overflow[0] !== 1'b1 || wr_ready[0] !== 1'b0 || lvl0 !== 3'd4) begin
         errors++; $display("FAIL ovf_full ovf=%b ready=%b level=%0d exp 1 0 4", overflow[0], wr_ready[0], lvl0);
      end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow[0]); end
      wr_valid = 1'b1; ovf_clr = 1'b1; tick(); wr_valid = 1'b0; ovf_clr = 1'b0;
      checks++; if (overflow[0] !== 1'b1 || lvl0 !== 3'd4) begin
         errors++; $display("FAIL ovf_set_beats_clr ovf=%b level=%0d exp 1 4", overflow[0], lvl0);
      end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      wait_idle(3'b001, 3000, "ovf_wait");
      build_exp();
      checks++; if (mon[0].nbits != exp_n || mon[0].bits !== exp_b || mon[0].dcs !== exp_d) begin
         errors++; $display("FAIL ovf_stream n=%0d data=%0h dc=%0h exp n=%0d data=%0h dc=%0h", mon[0].nbits, mon[0].bits, mon[0].dcs, exp_n, exp_b, exp_d);
      end
      checks++; if (mon[0].cs_falls != 1 || overflow[0] !== 1'b0) begin
         errors++; $display("FAIL ovf_window cs_windows=%0d ovf=%b exp 1 0", mon[0].cs_falls, overflow[0]);
      end
   endtask

   task automatic test_random();
      clear_mon();
      for (int n = 0; n < 6; n++) begin
         bit ok = 1'b0;
         for (int t = 0; t < 300; t++) begin
            if (wr_ready[0] === 1'b1) begin ok = 1'b1; break; end
            tick();
         end
         checks++; if (!ok) begin errors++; $display("FAIL rand_ready_timeout got %b exp 1", wr_ready[0]); end
         push(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom)));
         repeat ($urandom_range(0, 40)) tick();
      end
      wait_idle(3'b001, 2000, "rand_wait");
      build_exp();
      checks++; if (mon[0].nbits != exp_n || mon[0].bits !== exp_b) begin
         errors++; $display("FAIL rand_data n=%0d got %0h exp n=%0d %0h", mon[0].nbits, mon[0].bits, exp_n, exp_b);
      end
      checks++; if (mon[0].dcs !== exp_d) begin errors++; $display("FAIL rand_dc got %0h exp %0h", mon[0].dcs, exp_d); end
      checks++; if (mon[0].high_bad != 0 || mon[0].low_bad != 0 || mon[0].cs_bad != 0) begin
         errors++; $display("FAIL rand_sclk_timing high_bad=%0d low_bad=%0d cs_bad=%0d exp 0", mon[0].high_bad, mon[0].low_bad, mon[0].cs_bad);
      end
   endtask

   task automatic test_reset_midframe();
      bit ok = 1'b0;
      clear_mon();
      push(mk(1'b1, 1'b1, 16'($urandom)));
      push(mk(1'b0, 1'b1, 16'($urandom)));
      for (int i = 0; i < 500; i++) begin
         if (mon[0].edges >= 3) begin ok = 1'b1; break; end
         tick();
      end
      checks++; if (!ok || lvl0 !== 3'd1) begin
         errors++; $display("FAIL midrst_setup edges=%0d level=%0d exp >=3 1", mon[0].edges, lvl0);
      end
      rst = 1'b0;
      #1;
      checks++; if (tcs[0] !== 1'b1 || tclk[0] !== 1'b0 || lvl0 !== 3'd0 || busy[0] !== 1'b0) begin
         errors++; $display("FAIL midrst_abort cs=%b clk=%b level=%0d busy=%b exp 1 0 0 0", tcs[0], tclk[0], lvl0, busy[0]);
      end
      repeat (3) tick();
      rst = 1'b1;
      clear_mon();
      repeat (200) tick();
      checks++; if (mon[0].nbits != 0 || mon[0].cs_falls != 0 || busy[0] !== 1'b0) begin
         errors++; $display("FAIL midrst_residual bits=%0d cs_windows=%0d busy=%b exp 0 0 0", mon[0].nbits, mon[0].cs_falls, busy[0]);
      end
   endtask

   task automatic test_divider();
      rst = 1'b0; repeat (2) tick(); rst = 1'b1; tick();
      clear_mon();
      push(mk(1'b0, 1'b0, 16'h00A5));
      wait_idle(3'b111, 1000, "div_wait");
      build_exp();
      checks++; if (mon[1].nbits != 8 || mon[1].bits !== exp_b) begin
         errors++; $display("FAIL div1_data n=%0d got %0h exp 8 %0h", mon[1].nbits, mon[1].bits, exp_b);
      end
      checks++; if (mon[1].high_bad != 0 || mon[1].low_bad != 0 || mon[1].cs_gap != 1) begin
         errors++; $display("FAIL div1_timing high_bad=%0d low_bad=%0d cs_gap=%0d exp 0 0 1", mon[1].high_bad, mon[1].low_bad, mon[1].cs_gap);
      end
      checks++; if (mon[2].nbits != 8 || mon[2].bits !== exp_b) begin
         errors++; $display("FAIL div7_data n=%0d got %0h exp 8 %0h", mon[2].nbits, mon[2].bits, exp_b);
      end
      checks++; if (mon[2].high_bad != 0 || mon[2].low_bad != 0 || mon[2].cs_gap != 7) begin
         errors++; $display("FAIL div7_timing high_bad=%0d low_bad=%0d cs_gap=%0d exp 0 0 7", mon[2].high_bad, mon[2].low_bad, mon[2].cs_gap);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_random();
      test_reset_midframe();
      test_divider();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
